// File: rtl/bingo_card_engine_if.sv
// bingo_card_engine_if: keypad, draw and status signals of the bingo card engine
interface bingo_card_engine_if #(
  parameter int N_PLAYERS = 2,
  parameter int ENTRIES   = 8
);
  localparam int PW = N_PLAYERS > 1 ? $clog2(N_PLAYERS) : 1;
  localparam int IW = ENTRIES > 1 ? $clog2(ENTRIES) : 1;
  localparam int CW = $clog2(ENTRIES + 1);
  logic                    digit_valid;
  logic [3:0]              digit;
  logic                    draw_valid;
  logic [7:0]              draw_number;
  logic                    clear_game;
  logic [1:0]              state;
  logic                    ready;
  logic [PW-1:0]           load_player;
  logic [IW-1:0]           load_index;
  logic                    entry_error;
  logic                    draw_done;
  logic                    hit;
  logic [N_PLAYERS*CW-1:0] remaining;
  logic [N_PLAYERS-1:0]    winner;
  logic                    game_over;
  modport master (
    output digit_valid, digit, draw_valid, draw_number, clear_game,
    input  state, ready, load_player, load_index, entry_error, draw_done, hit,
           remaining, winner, game_over
  );
  modport slave (
    input  digit_valid, digit, draw_valid, draw_number, clear_game,
    output state, ready, load_player, load_index, entry_error, draw_done, hit,
           remaining, winner, game_over
  );
endinterface

// File: rtl/bingo_card_engine.sv
// bingo_card_engine: keypad-loaded bingo cards, one-entry-per-cycle draw scan, winner detection
module bingo_card_engine #(
  parameter int N_PLAYERS = 2,
  parameter int ENTRIES   = 8
) (
  input logic                clk,
  input logic                rst,
  bingo_card_engine_if.slave bus
);
  localparam int PW = N_PLAYERS > 1 ? $clog2(N_PLAYERS) : 1;
  localparam int IW = ENTRIES > 1 ? $clog2(ENTRIES) : 1;
  localparam int CW = $clog2(ENTRIES + 1);
  typedef enum logic [1:0] {LOAD = 2'd0, READY = 2'd1, SCAN = 2'd2, OVER = 2'd3} state_t;
  state_t               state_q, state_d;
  logic [7:0]           card_q [N_PLAYERS][ENTRIES];
  logic [7:0]           card_d [N_PLAYERS][ENTRIES];
  logic [CW-1:0]        rem_q [N_PLAYERS];
  logic [CW-1:0]        rem_d [N_PLAYERS];
  logic [PW-1:0]        player_q, player_d, sp_q, sp_d;
  logic [IW-1:0]        index_q, index_d, si_q, si_d;
  logic [3:0]           tens_q, tens_d;
  logic [7:0]           draw_q, draw_d;
  logic [N_PLAYERS-1:0] win_q, win_d;
  logic                 pend_q, pend_d, err_q, err_d, done_q, done_d, hit_q, hit_d, acc_q, acc_d;
  logic [7:0]           val;
  logic                 dup, match, last_i, last_p, last_sp;
  always_comb begin
    state_d  = state_q;
    card_d   = card_q;
    rem_d    = rem_q;
    player_d = player_q;
    index_d  = index_q;
    sp_d     = sp_q;
    si_d     = si_q;
    tens_d   = tens_q;
    pend_d   = pend_q;
    draw_d   = draw_q;
    win_d    = win_q;
    acc_d    = acc_q;
    err_d    = 1'b0;
    done_d   = 1'b0;
    hit_d    = 1'b0;
    val      = {4'd0, tens_q} * 8'd10 + {4'd0, bus.digit};
    dup      = val == 8'd0;
    for (int j = 0; j < ENTRIES; j++) dup = dup | (card_q[player_q][j] == val);
    match    = card_q[sp_q][si_q] == draw_q && draw_q != 8'd0;
    last_i   = index_q == IW'(ENTRIES - 1);
    last_p   = player_q == PW'(N_PLAYERS - 1);
    last_sp  = sp_q == PW'(N_PLAYERS - 1);
    if (bus.clear_game) begin
      state_d  = LOAD;
      card_d   = '{default: '0};
      rem_d    = '{default: '0};
      player_d = '0;
      index_d  = '0;
      sp_d     = '0;
      si_d     = '0;
      tens_d   = '0;
      pend_d   = 1'b0;
      draw_d   = '0;
      win_d    = '0;
      acc_d    = 1'b0;
    end else begin
      case (state_q)
        LOAD: if (bus.digit_valid) begin
          if (bus.digit > 4'd9) begin
            err_d  = 1'b1;
            pend_d = 1'b0;
          end else if (!pend_q) begin
            tens_d = bus.digit;
            pend_d = 1'b1;
          end else begin
            pend_d = 1'b0;
            if (dup) err_d = 1'b1;
            else begin
              card_d[player_q][index_q] = val;
              rem_d[player_q] = rem_q[player_q] + CW'(1);
              index_d  = last_i ? '0 : index_q + IW'(1);
              player_d = !last_i ? player_q : last_p ? '0 : player_q + PW'(1);
              state_d  = last_i && last_p ? READY : LOAD;
            end
          end
        end
        READY: if (bus.draw_valid) begin
          draw_d  = bus.draw_number;
          sp_d    = '0;
          si_d    = '0;
          acc_d   = 1'b0;
          state_d = SCAN;
        end
        SCAN: begin
          if (match) begin
            card_d[sp_q][si_q] = '0;
            rem_d[sp_q] = rem_q[sp_q] - CW'(1);
          end
          acc_d = acc_q | match;
          si_d  = si_q == IW'(ENTRIES - 1) ? '0 : si_q + IW'(1);
          sp_d  = si_q != IW'(ENTRIES - 1) ? sp_q : last_sp ? '0 : sp_q + PW'(1);
          // last visit: winners come from the counts as updated by this very visit
          if (si_q == IW'(ENTRIES - 1) && last_sp) begin
            done_d = 1'b1;
            hit_d  = acc_q | match;
            for (int p = 0; p < N_PLAYERS; p++) win_d[p] = rem_d[p] == '0;
            state_d = |win_d ? OVER : READY;
          end
        end
        OVER: ;
        default: state_d = LOAD;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD;
      card_q   <= '{default: '0};
      rem_q    <= '{default: '0};
      player_q <= '0;
      index_q  <= '0;
      sp_q     <= '0;
      si_q     <= '0;
      tens_q   <= '0;
      pend_q   <= 1'b0;
      draw_q   <= '0;
      win_q    <= '0;
      acc_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      card_q   <= card_d;
      rem_q    <= rem_d;
      player_q <= player_d;
      index_q  <= index_d;
      sp_q     <= sp_d;
      si_q     <= si_d;
      tens_q   <= tens_d;
      pend_q   <= pend_d;
      draw_q   <= draw_d;
      win_q    <= win_d;
      acc_q    <= acc_d;
      err_q    <= err_d;
      done_q   <= done_d;
      hit_q    <= hit_d;
    end
  end
  assign bus.state       = state_q;
  assign bus.ready       = state_q == READY;
  assign bus.game_over   = state_q == OVER;
  assign bus.load_player = player_q;
  assign bus.load_index  = index_q;
  assign bus.entry_error = err_q;
  assign bus.draw_done   = done_q;
  assign bus.hit         = hit_q;
  assign bus.winner      = win_q;
  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_rem
    assign bus.remaining[p*CW +: CW] = rem_q[p];
  end
endmodule

// File: doc/bingo_card_engine.md
BINGO_CARD_ENGINE -- requirements
Module: bingo_card_engine

Interface
REQ-001 SHALL have parameter N_PLAYERS, default 2, number of player cards.
REQ-002 SHALL have parameter ENTRIES, default 8, numbers per card.
REQ-003 SHALL derive widths: PW=max(1,clog2(N_PLAYERS)), IW=max(1,clog2(ENTRIES)), CW=clog2(ENTRIES+1).
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- digit_valid  in  1  one-cycle keypad digit strobe.
- digit  in  4  keypad digit value.
- draw_valid  in  1  one-cycle draw request.
- draw_number  in  8  binary drawn number.
- clear_game  in  1  one-cycle restart request.
- state  out  2  0=LOAD, 1=READY, 2=SCAN, 3=OVER.
- ready  out  1  high only in READY.
- load_player  out  PW  card being filled.
- load_index  out  IW  next slot being filled.
- entry_error  out  1  one-cycle pulse on a rejected entry.
- draw_done  out  1  one-cycle pulse when a draw completes.
- hit  out  1  one-cycle pulse with draw_done when at least one entry was struck.
- remaining  out  N_PLAYERS*CW  per-player unstruck count; player p at bits [p*CW +: CW].
- winner  out  N_PLAYERS  one bit per player with remaining==0 at game end.
- game_over  out  1  high in OVER.

Function
REQ-005 SHALL store cards in registers: N_PLAYERS*ENTRIES 8-bit values; value 0 means empty or struck.
REQ-006 LOAD: first accepted digit is tens, latched as pending; second is units; value = tens*10+units, stored at [load_player][load_index] on the second strobe's edge.
REQ-007 A digit >9 SHALL pulse entry_error, discard any pending tens digit, and store nothing.
REQ-008 A composed value of 0, or a value already on the current player's card, SHALL pulse entry_error, store nothing, and leave load_index unchanged.
REQ-009 Each store SHALL increment remaining[load_player] and load_index; when load_index==ENTRIES-1 is stored, load_index wraps to 0 and load_player increments.
REQ-010 A store into the last slot of the last player SHALL move LOAD->READY on the same edge.
REQ-011 READY: draw_valid SHALL latch draw_number, clear the scan pointer, and move to SCAN.
REQ-012 SCAN SHALL visit exactly one entry per cycle, player-major order, N_PLAYERS*ENTRIES cycles total.
REQ-013 A visited entry equal to the latched draw and nonzero SHALL be zeroed, and that player's remaining decremented, on the same edge.
REQ-014 Latency: with draw_valid sampled at edge 0, the last entry is visited at edge N_PLAYERS*ENTRIES; draw_done (and hit, if applicable) SHALL be high for exactly the following cycle.
REQ-015 On leaving SCAN: if any remaining==0, SHALL set winner to the bitmask of zero-count players (ties allowed) and enter OVER; else return to READY.
REQ-016 Draw values 0 or >99 SHALL be scanned normally and produce no hit.
REQ-017 digit_valid outside LOAD, and draw_valid outside READY, SHALL be ignored with no queuing and no error.
REQ-018 OVER SHALL hold all outputs until clear_game or rst.
REQ-019 clear_game SHALL, in any state, return to LOAD on the next edge: clear all entries, remaining, winner, pointers, pending digit, and latched draw.
REQ-020 Priority SHALL be rst > clear_game > digit_valid/draw_valid.

Reset
REQ-021 On rst sampled high, SHALL set state=LOAD, clear all entries, load_player=0, load_index=0, remaining=0, winner=0, and drive ready, entry_error, draw_done, hit and game_over low, effective from the next cycle, including mid-SCAN.

Verification (defaults N_PLAYERS=2, ENTRIES=8)
REQ-022 Reset -> state=0, load_player=0, load_index=0, remaining=0, winner=0, ready=0.
REQ-023 Digits 4,2 -> entry 42 stored, load_index=1, remaining[0]=1; then 4,2 again -> entry_error pulse, load_index stays 1.
REQ-024 Digit 11 -> entry_error, pending tens discarded; then 0,0 -> entry_error; then 0,7 -> 7 stored.
REQ-025 Load P0 with 1..8 and P1 with 11..18 -> READY after the 16th store; draw 5 -> ready low 16 cycles, then draw_done=hit=1, remaining[0]=7; draw 50 -> draw_done=1, hit=0.
REQ-026 Draws 1..8 -> after the 8th, winner=2'b01, game_over=1, state=3; further draw_valid ignored; clear_game -> state=0, remaining=0.
REQ-027 draw_valid pulsed mid-SCAN -> ignored, exactly one draw_done; rst mid-SCAN -> REQ-021 values on the next cycle.
